// File: rtl/hpm_pkg.sv
// Shared definitions for the hardware performance-monitor counter bank.
// Register offsets, CFG bit positions and the per-counter config bundle.
package hpm_pkg;

  localparam int unsigned EVT_SEL_MAX_W = 8;

  localparam logic [1:0] CNT_LO = 2'd0;
  localparam logic [1:0] CNT_HI = 2'd1;
  localparam logic [1:0] CFG    = 2'd2;

  localparam logic [7:0] INHIBIT = 8'hF0;
  localparam logic [7:0] OVF     = 8'hF1;
  localparam logic [7:0] ID      = 8'hF2;

  localparam int unsigned CFG_EN_BIT     = 16;
  localparam int unsigned CFG_IRQ_EN_BIT = 17;

  typedef struct packed {
    logic [EVT_SEL_MAX_W-1:0] evt_sel;
    logic                     en;
    logic                     irq_en;
  } hpm_cfg_t;

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// Single event counter: half-word bus writes beat increments,
// and a wrap pulse flags the all-ones to zero transition.
module hpm_counter #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata_lo,
  input  logic [CNT_WIDTH-33:0] wdata_hi,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 wrap
);

  logic [CNT_WIDTH-1:0] cnt;
  logic                 bump;

  assign bump  = inc & ~wr_lo & ~wr_hi;
  assign wrap  = bump & (&cnt);
  assign value = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wr_lo | wr_hi) begin
      if (wr_lo) cnt[31:0] <= wdata_lo;
      if (wr_hi) cnt[CNT_WIDTH-1:32] <= wdata_hi;
    end else if (bump) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Programmable performance-monitor bank: event counters, inhibit,
// overflow status/interrupt and atomic 64-bit reads on a 32-bit port.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS = 8,
  parameter int unsigned NUM_EVENTS   = 16,
  parameter int unsigned CNT_WIDTH    = 64,
  parameter int unsigned XLEN         = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [7:0]            reg_addr_i,
  input  logic [XLEN-1:0]       reg_wdata_i,
  output logic [XLEN-1:0]       reg_rdata_o,
  output logic                  reg_ack_o,
  output logic                  irq_o
);

  localparam int unsigned EVT_SEL_WIDTH =
    (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int unsigned HI_W = CNT_WIDTH - 32;

  logic [5:0] idx;
  logic [1:0] off;
  logic       in_bank;
  logic       rd_req;
  logic       wr_req;

  assign idx     = reg_addr_i[7:2];
  assign off     = reg_addr_i[1:0];
  assign in_bank = 32'(idx) < NUM_COUNTERS;
  assign rd_req  = reg_req_i & ~reg_we_i;
  assign wr_req  = reg_req_i & reg_we_i;

  hpm_cfg_t             cfg   [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0] value [NUM_COUNTERS];

  logic [NUM_COUNTERS-1:0] wrap;
  logic [NUM_COUNTERS-1:0] inc;
  logic [NUM_COUNTERS-1:0] irq_en_vec;
  logic [NUM_COUNTERS-1:0] inhibit;
  logic [NUM_COUNTERS-1:0] ovf;
  logic [NUM_COUNTERS-1:0] ovf_clr;

  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] hi_latch;
  logic [XLEN-1:0] rd_val;
  logic            ack;
  logic            irq;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    hpm_cfg_t cfg_q;
    logic     hit;
    logic     here;
    logic     wr_lo;
    logic     wr_hi;

    assign here  = wr_req & in_bank & (idx == 6'(i));
    assign wr_lo = here & (off == CNT_LO);
    assign wr_hi = here & (off == CNT_HI);

    // Out-of-range selects never match, so they never count.
    always_comb begin
      hit = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (cfg_q.evt_sel == EVT_SEL_MAX_W'(e)) hit = event_i[e];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cfg_q <= '0;
      end else if (here && off == CFG) begin
        cfg_q.evt_sel <= EVT_SEL_MAX_W'(reg_wdata_i[EVT_SEL_WIDTH-1:0]);
        cfg_q.en      <= reg_wdata_i[CFG_EN_BIT];
        cfg_q.irq_en  <= reg_wdata_i[CFG_IRQ_EN_BIT];
      end
    end

    assign cfg[i]        = cfg_q;
    assign irq_en_vec[i] = cfg_q.irq_en;
    assign inc[i]        = cfg_q.en & ~inhibit[i] & hit;

    hpm_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .inc     (inc[i]),
      .wr_lo   (wr_lo),
      .wr_hi   (wr_hi),
      .wdata_lo(reg_wdata_i[31:0]),
      .wdata_hi(reg_wdata_i[HI_W-1:0]),
      .value   (value[i]),
      .wrap    (wrap[i])
    );
  end

  logic [CNT_WIDTH-1:0] sel_value;
  hpm_cfg_t             sel_cfg;

  always_comb begin
    sel_value = '0;
    sel_cfg   = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx == 6'(i)) begin
        sel_value = value[i];
        sel_cfg   = cfg[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      in_bank && off == CNT_LO: rd_val = sel_value[31:0];
      in_bank && off == CNT_HI: rd_val = hi_latch;
      in_bank && off == CFG: begin
        rd_val[EVT_SEL_MAX_W-1:0]   = sel_cfg.evt_sel;
        rd_val[CFG_EN_BIT]     = sel_cfg.en;
        rd_val[CFG_IRQ_EN_BIT] = sel_cfg.irq_en;
      end
      reg_addr_i == INHIBIT: rd_val = XLEN'(inhibit);
      reg_addr_i == OVF:     rd_val = XLEN'(ovf);
      reg_addr_i == ID:
        rd_val = {16'(CNT_WIDTH), 16'(NUM_COUNTERS)};
      default: rd_val = '0;
    endcase
  end

  assign ovf_clr = (wr_req && reg_addr_i == OVF)
                 ? reg_wdata_i[NUM_COUNTERS-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack      <= 1'b0;
      rdata    <= '0;
      hi_latch <= '0;
      inhibit  <= '0;
      ovf      <= '0;
      irq      <= 1'b0;
    end else begin
      ack <= reg_req_i;
      irq <= |(ovf & irq_en_vec);
      // A fresh wrap outranks a simultaneous clear.
      ovf <= (ovf & ~ovf_clr) | wrap;
      if (reg_req_i) rdata <= reg_we_i ? '0 : rd_val;
      if (rd_req && in_bank && off == CNT_LO)
        hi_latch <= XLEN'(sel_value[CNT_WIDTH-1:32]);
      if (wr_req && reg_addr_i == INHIBIT)
        inhibit <= reg_wdata_i[NUM_COUNTERS-1:0];
    end
  end

  assign reg_rdata_o = rdata;
  assign reg_ack_o   = ack;
  assign irq_o       = irq;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised and directed bench for hpm_counter_bank against an
// arithmetic model of counters, config, inhibit and overflow.
module tb_hpm_counter_bank;

  localparam int NC = 8;
  localparam int NE = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NE-1:0] event_i = '0;
  logic          reg_req_i = 1'b0;
  logic          reg_we_i = 1'b0;
  logic [7:0]    reg_addr_i = '0;
  logic [31:0]   reg_wdata_i = '0;
  logic [31:0]   reg_rdata_o;
  logic          reg_ack_o;
  logic          irq_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hpm_counter_bank dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .event_i    (event_i),
    .reg_req_i  (reg_req_i),
    .reg_we_i   (reg_we_i),
    .reg_addr_i (reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_rdata_o(reg_rdata_o),
    .reg_ack_o  (reg_ack_o),
    .irq_o      (irq_o)
  );

  longint unsigned m_cnt [NC];
  logic [7:0]      m_sel [NC];
  bit              m_en  [NC];
  bit              m_ie  [NC];
  logic [NC-1:0]   m_inh;
  logic [NC-1:0]   m_ovf;
  logic [31:0]     m_hi;
  logic [31:0]     m_rd;
  bit              m_irq;
  bit              m_ack;

  task automatic m_reset();
    for (int j = 0; j < NC; j++) begin
      m_cnt[j] = 0; m_sel[j] = '0; m_en[j] = 0; m_ie[j] = 0;
    end
    m_inh = '0; m_ovf = '0; m_hi = '0; m_rd = '0;
    m_irq = 0; m_ack = 0;
  endtask

  // Drive one cycle, advance the model to its post-edge state, settle.
  task automatic step(input logic [NE-1:0] ev, input logic req,
                      input logic we, input logic [7:0] addr,
                      input logic [31:0] wd);
    int i;
    int k;
    logic [31:0]   rd;
    logic [NC-1:0] ovf_n;
    logic [NC-1:0] iev;
    bit            irq_n;
    event_i = ev; reg_req_i = req; reg_we_i = we;
    reg_addr_i = addr; reg_wdata_i = wd;
    i = int'(addr) / 4;
    k = int'(addr) % 4;
    for (int j = 0; j < NC; j++) iev[j] = m_ie[j];
    irq_n = |(m_ovf & iev);
    rd = '0;
    if (addr < 8'(4 * NC)) begin
      if (k == 0) rd = m_cnt[i][31:0];
      else if (k == 1) rd = m_hi;
      else if (k == 2) rd = {14'd0, m_ie[i], m_en[i], 8'd0, m_sel[i]};
    end else if (addr == 8'hF0) rd = 32'(m_inh);
    else if (addr == 8'hF1) rd = 32'(m_ovf);
    else if (addr == 8'hF2) rd = (32'd64 << 16) | 32'(NC);
    if (req && !we && addr < 8'(4 * NC) && k == 0) m_hi = m_cnt[i][63:32];
    ovf_n = m_ovf;
    if (req && we && addr == 8'hF1) ovf_n &= ~wd[NC-1:0];
    for (int j = 0; j < NC; j++) begin
      if (req && we && addr < 8'(4 * NC) && i == j && k < 2) begin
        if (k == 0) m_cnt[j][31:0] = wd;
        else m_cnt[j][63:32] = wd;
      end else if (m_en[j] && !m_inh[j] && m_sel[j] < NE && ev[m_sel[j]]) begin
        if (m_cnt[j] == 64'hFFFF_FFFF_FFFF_FFFF) ovf_n[j] = 1'b1;
        m_cnt[j] = m_cnt[j] + 1;
      end
    end
    if (req && we && addr < 8'(4 * NC) && k == 2) begin
      m_sel[i] = {4'd0, wd[3:0]}; m_en[i] = wd[16]; m_ie[i] = wd[17];
    end
    if (req && we && addr == 8'hF0) m_inh = wd[NC-1:0];
    m_ovf = ovf_n; m_irq = irq_n; m_ack = req;
    if (req && !we) m_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NE-1:0] ev);
    step(ev, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [NE-1:0] ev);
    step(ev, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [NE-1:0] ev);
    step(ev, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic test_reset();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (reg_ack_o !== 1'b0 || reg_rdata_o !== 32'd0 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs ack=%b rdata=%h irq=%b want 0", reg_ack_o, reg_rdata_o, irq_o);
    end
    rst_ni = 1'b1;
    idle('0);
    rd(8'hF2, '0);
    total++;
    if (reg_ack_o !== 1'b1 || reg_rdata_o !== 32'h0040_0008) begin
      bad++;
      $display("FAIL id ack=%b rdata=%h want 1/00400008", reg_ack_o, reg_rdata_o);
    end
    idle('0);
    total++;
    if (reg_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL ack_single got=%b want 0", reg_ack_o);
    end
    for (int a = 0; a < 4 * NC; a++) begin
      rd(8'(a), '0);
      total++;
      if (reg_rdata_o !== 32'd0 || irq_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_reg a=%0d rdata=%h irq=%b want 0", a, reg_rdata_o, irq_o);
      end
    end
  endtask

  task automatic test_basic_count();
    logic [9:0] pat;
    pat = 10'b1101101101;
    wr(8'd6, 32'h0001_0003, '0);
    for (int n = 0; n < 10; n++) idle(NE'(pat[n]) << 3);
    rd(8'd4, '0);
    total++;
    if (reg_rdata_o !== 32'd7 || reg_rdata_o !== m_rd) begin
      bad++;
      $display("FAIL basic_lo got=%h want=%h", reg_rdata_o, 32'd7);
    end
    rd(8'd5, '0);
    total++;
    if (reg_rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL basic_hi got=%h want=0", reg_rdata_o);
    end
    wr(8'hF0, 32'h2, '0);
    repeat (5) idle(NE'(1) << 3);
    rd(8'd4, '0);
    total++;
    if (reg_rdata_o !== 32'd7) begin
      bad++;
      $display("FAIL inhibit got=%h want=7", reg_rdata_o);
    end
  endtask

  task automatic test_atomic_read();
    logic [31:0] lo;
    logic [31:0] hi;
    logic [NE-1:0] ev;
    ev = NE'(1) << 5;
    wr(8'd9, 32'd0, ev);
    wr(8'd8, 32'hFFFF_FFFF, ev);
    wr(8'd10, 32'h0001_0005, ev);
    for (int n = 0; n < 3; n++) begin
      rd(8'd8, ev);
      lo = reg_rdata_o;
      total++;
      if (lo !== m_rd) begin
        bad++;
        $display("FAIL atomic_lo got=%h want=%h", lo, m_rd);
      end
      rd(8'd9, ev);
      hi = reg_rdata_o;
      total++;
      if (hi !== m_rd ||
          !((hi == 0 && lo[31:8] == 24'hFFFFFF) || (hi == 1 && lo < 32'h100))) begin
        bad++;
        $display("FAIL atomic_pair lo=%h hi=%h want consistent hi=%h", lo, hi, m_rd);
      end
    end
    idle('0);
  endtask

  task automatic test_overflow_irq();
    wr(8'd1, 32'hFFFF_FFFF, '0);
    wr(8'd0, 32'hFFFF_FFFF, '0);
    wr(8'd2, 32'h0003_0000, '0);
    idle(NE'(1));
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_early got=%b want 0", irq_o);
    end
    idle('0);
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_rise got=%b want 1", irq_o);
    end
    rd(8'd0, '0);
    total++;
    if (reg_rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL wrap_lo got=%h want 0", reg_rdata_o);
    end
    rd(8'hF1, '0);
    total++;
    if (reg_rdata_o !== 32'd1) begin
      bad++;
      $display("FAIL ovf_set got=%h want 1", reg_rdata_o);
    end
    wr(8'hF1, 32'd1, '0);
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_hold got=%b want 1", irq_o);
    end
    idle('0);
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall got=%b want 0", irq_o);
    end
  endtask

  task automatic test_collisions();
    wr(8'd14, 32'h0001_0002, '0);
    wr(8'd12, 32'h55, NE'(1) << 2);
    rd(8'd12, '0);
    total++;
    if (reg_rdata_o !== 32'h55) begin
      bad++;
      $display("FAIL write_wins got=%h want 55", reg_rdata_o);
    end
    wr(8'd1, 32'hFFFF_FFFF, '0);
    wr(8'd0, 32'hFFFF_FFFF, '0);
    wr(8'hF1, 32'd1, NE'(1));
    rd(8'hF1, '0);
    total++;
    if (reg_rdata_o[0] !== 1'b1 || reg_rdata_o !== m_rd) begin
      bad++;
      $display("FAIL set_wins got=%h want=%h", reg_rdata_o, m_rd);
    end
  endtask

  task automatic test_random();
    bit last_rd;
    for (int n = 0; n < 400; n++) begin
      automatic int          pick = $urandom_range(0, 9);
      automatic logic [7:0]  a;
      automatic logic [31:0] d = $urandom;
      automatic logic        q = ($urandom_range(0, 3) != 0);
      automatic logic        w = ($urandom_range(0, 2) == 0);
      if (pick < 6) a = 8'($urandom_range(0, 4 * NC - 1));
      else if (pick == 6) a = 8'hF0;
      else if (pick == 7) a = 8'hF1;
      else if (pick == 8) a = 8'hF2;
      else a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF;
      last_rd = q && !w;
      step(NE'($urandom), q, w, a, d);
      total++;
      if (reg_ack_o !== m_ack || irq_o !== m_irq ||
          (last_rd && reg_rdata_o !== m_rd)) begin
        bad++;
        $display("FAIL random n=%0d ack=%b irq=%b rdata=%h want %b/%b/%h",
                 n, reg_ack_o, irq_o, reg_rdata_o, m_ack, m_irq, m_rd);
      end
    end
  endtask

  task automatic test_async_reset();
    wr(8'hF0, 32'd0, '0);
    wr(8'd2, 32'h0003_0000, '0);
    wr(8'd1, 32'hFFFF_FFFF, '0);
    wr(8'd0, 32'hFFFF_FFFF, '0);
    idle(NE'(1));
    idle('0);
    event_i = '1; reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 8'hF2;
    @(posedge clk);
    #1;
    total++;
    if (reg_ack_o !== 1'b1 || irq_o !== 1'b1 || reg_rdata_o !== 32'h0040_0008) begin
      bad++;
      $display("FAIL pre_reset ack=%b irq=%b rdata=%h want 1/1/00400008",
               reg_ack_o, irq_o, reg_rdata_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (reg_ack_o !== 1'b0 || irq_o !== 1'b0 || reg_rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL async_reset ack=%b irq=%b rdata=%h want 0", reg_ack_o, irq_o, reg_rdata_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (reg_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL inflight_ack got=%b want 0", reg_ack_o);
    end
    reg_req_i = 1'b0;
    event_i = '0;
    rst_ni = 1'b1;
    m_reset();
    idle('0);
    rd(8'd0, '1);
    total++;
    if (reg_rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL post_reset_cnt got=%h want 0", reg_rdata_o);
    end
    rd(8'd2, '0);
    total++;
    if (reg_rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL post_reset_cfg got=%h want 0", reg_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_atomic_read();
    test_overflow_irq();
    test_collisions();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
Parametrised hardware performance-monitor bank replacing the fixed cycle/instr/stall counters in the core top. It provides NUM_COUNTERS programmable event counters, each selecting one of NUM_EVENTS pulse inputs from the pipeline (retire, hazard stall, branch taken, imem/dmem wait, …). Features are per-counter enable, a global inhibit, overflow status with interrupt, and atomic 64-bit reads over a 32-bit register bus. It sits beside the pipeline and is read by software or debug through a simple single-cycle register port.

Parameters:
NUM_COUNTERS, 8, number of counters, 1..32.
NUM_EVENTS, 16, number of event inputs, 1..256.
CNT_WIDTH, 64, counter width, 33..64.
XLEN, 32, register bus data width, fixed 32.
EVT_SEL_WIDTH, $clog2(NUM_EVENTS) (minimum 1), width of the event-select field.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
event_i  in  NUM_EVENTS  event pulses, one count per cycle high.
reg_req_i  in  1  register access request, one access per cycle.
reg_we_i  in  1  1 = write, 0 = read.
reg_addr_i  in  8  word index.
reg_wdata_i  in  XLEN  write data.
reg_rdata_o  out  XLEN  read data, valid with ack.
reg_ack_o  out  1  access acknowledge.
irq_o  out  1  overflow interrupt, level.

Behaviour:
Reset
- Asynchronous reset applies immediately on rst_ni low.
- Reset values: all counters 0; all CFG 0; INHIBIT 0; OVF 0; reg_ack_o 0; reg_rdata_o 0; irq_o 0; hi_latch 0.

Register map (word index)
- 4*i+0 CNT_LO[i]: counter bits [31:0].
- 4*i+1 CNT_HI[i]: counter bits [CNT_WIDTH-1:32], zero-extended.
- 4*i+2 CFG[i]: bits [EVT_SEL_WIDTH-1:0] evt_sel; bit16 en; bit17 irq_en; other bits read 0.
- 4*i+3: reserved.
- 0xF0 INHIBIT: bit i freezes counter i.
- 0xF1 OVF: status, write-1-to-clear.
- 0xF2 ID: read-only, {16'(CNT_WIDTH), 16'(NUM_COUNTERS)}.
- Reserved, unmapped and i ≥ NUM_COUNTERS addresses: read 0, writes ignored, still acked.

Bus
- reg_ack_o is asserted exactly 1 cycle after each reg_req_i and for that cycle only. Back-to-back requests get one ack per cycle.
- reg_rdata_o is registered and holds its value between acks.
- Reading CNT_LO[i] returns the value in the request cycle and, in the same edge, loads hi_latch with that cycle's upper bits. There is one shared hi_latch.
- Reading CNT_HI[i] for any i returns hi_latch, so a LO-then-HI pair is atomic. Software must pair accesses on the same counter.
- Writing CNT_LO or CNT_HI replaces only that half of the counter.

Counting
- Counter i increments by 1 at the edge when en & !INHIBIT[i] & event_i[evt_sel] & (evt_sel < NUM_EVENTS).
- An evt_sel value ≥ NUM_EVENTS never counts.
- Counters wrap modulo 2^CNT_WIDTH. A wrap from all-ones to 0 sets OVF[i] at that edge.
- A bus write to counter i in the same cycle as an increment: the write wins, there is no increment and no OVF set.
- OVF W1C in the same cycle as a new overflow on that bit: set wins.
- irq_o is registered: irq_o = |(OVF & irq_en vector), so it rises 1 cycle after the OVF bit sets and falls 1 cycle after the clear.
- A CFG write takes effect for events from the next cycle onward.

Decomposition:
- Package hpm_pkg:
  - Register-offset localparams (CNT_LO, CNT_HI, CFG, INHIBIT 0xF0, OVF 0xF1, ID 0xF2).
  - CFG bit positions (CFG_EN_BIT = 16, CFG_IRQ_EN_BIT = 17).
  - A packed struct hpm_cfg_t {evt_sel, en, irq_en}.
- Sub-module hpm_counter: one counter holding the register, increment, half-word write with priority, and the wrap/overflow pulse. The bank generates NUM_COUNTERS instances plus the bus decode, hi_latch, OVF/INHIBIT and irq logic.

Test Plan:
- Reset and ID: deassert rst_ni, read ID -> ack 1 cycle later with rdata 0x0040_0008; every counter and CFG reads 0; irq_o 0.
- Basic count: CFG[1] = en, evt_sel 3; pulse event_i[3] for 10 cycles, of which 7 are high -> CNT_LO[1] = 7, CNT_HI[1] = 0. Set INHIBIT bit1 and pulse 5 more -> count still 7.
- Atomic read: write CNT_HI[2] = 0, CNT_LO[2] = 0xFFFF_FFFF; enable counting with the event held high. Read LO then HI -> the LO value is consistent with HI across the 32-bit carry (e.g. LO 0xFFFF_FFFF with HI 0, or LO 0x0000_000x with HI 1), never a mismatched pair.
- Overflow and irq: CNT_HI/LO[0] = all-ones, CFG[0] = en + irq_en, one event pulse -> counter 0 reads 0, OVF bit0 set, irq_o high one cycle later. Write OVF = 0x1 -> irq_o low one cycle after the clear.
- Collisions: write CNT_LO[3] = 0x55 in an event cycle -> reads exactly 0x55. W1C OVF bit in the same cycle as a new wrap -> bit remains 1.
- Async reset mid-count: drop rst_ni between clock edges while counting -> all outputs 0 immediately; no ack is issued for the in-flight request.
